// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth 32x32 signed multiplier.
// All datapath add/subtract goes through a 32-bit two-level carry-lookahead adder.

module booth_cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       gg,
    output logic       pg
);
    logic [7:0] g, p, c;
    logic       pr;

    // Each carry is a flat sum of products of g/p terms, not a ripple chain.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        pr   = 1'b1;
        gg   = 1'b0;
        for (int i = 1; i < 8; i++) begin
            pr = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & pr);
                pr   = pr & p[j];
            end
            c[i] = c[i] | (cin & pr);
        end
        pr = 1'b1;
        for (int j = 7; j >= 0; j--) begin
            gg = gg | (g[j] & pr);
            pr = pr & p[j];
        end
        pg  = &p;
        sum = p ^ c;
    end
endmodule

module booth_cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [3:0] gg, pg;
    logic [4:0] bc;
    logic       pr;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_blk
            booth_cla8 u_blk (
                .a   (a[8*k +: 8]),
                .b   (b[8*k +: 8]),
                .cin (bc[k]),
                .sum (sum[8*k +: 8]),
                .gg  (gg[k]),
                .pg  (pg[k])
            );
        end
    endgenerate

    // Second-level lookahead across the four block G/P pairs.
    always_comb begin
        bc    = '0;
        bc[0] = cin;
        pr    = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pr = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                bc[i] = bc[i] | (gg[j] & pr);
                pr    = pr & pg[j];
            end
            bc[i] = bc[i] | (cin & pr);
        end
        cout = bc[4];
    end
endmodule

module booth_mult_seq #(
    parameter int ITERS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] ac, q, m;
    logic        q_m1;
    logic [4:0]  counter;
    logic        last_iter;

    logic        use_add, do_sub, ovf, unused_cout;
    logic [31:0] opb, add_sum, sum, ac_nxt, q_nxt;
    logic        exc_nxt;

    assign last_iter   = (state == RUN) && (counter == 5'(ITERS - 1));
    assign data_result = q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (ctrl_MULT) state_nxt = RUN;
    end

    assign do_sub  = q[0] & ~q_m1;
    assign use_add = q[0] ^ q_m1;
    assign opb     = do_sub ? ~m : m;

    booth_cla32 u_add (
        .a    (ac),
        .b    (opb),
        .cin  (do_sub),
        .sum  (add_sum),
        .cout (unused_cout)
    );

    // Correcting the shifted-in sign with the overflow flag keeps M = 0x80000000 exact.
    always_comb begin
        sum     = use_add ? add_sum : ac;
        ovf     = use_add && (ac[31] == opb[31]) && (sum[31] != ac[31]);
        ac_nxt  = {sum[31] ^ ovf, sum[31:1]};
        q_nxt   = {sum[0], q[31:1]};
        exc_nxt = (ac_nxt != {32{q_nxt[31]}});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            ac             <= '0;
            q              <= '0;
            q_m1           <= 1'b0;
            m              <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ctrl_MULT) begin
                m              <= data_operandA;
                q              <= data_operandB;
                ac             <= '0;
                q_m1           <= 1'b0;
                counter        <= '0;
                data_resultRDY <= 1'b0;
                data_exception <= 1'b0;
                busy           <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        ac      <= ac_nxt;
                        q       <= q_nxt;
                        q_m1    <= q[0];
                        counter <= counter + 5'd1;
                        if (last_iter) begin
                            data_resultRDY <= 1'b1;
                            data_exception <= exc_nxt;
                            busy           <= 1'b0;
                        end
                    end
                    DONE:    data_resultRDY <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: product model from plain 64-bit multiplication,
// per-cycle compare, plus directed vectors with literal expectations.

module tb_booth_mult_seq;
    logic        clock = 1'b0;
    logic        reset, ctrl_MULT;
    logic [31:0] a, b;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int n_pass = 0;
    int n_chk  = 0;
    int rdy_cnt = 0;

    booth_mult_seq #(.ITERS(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (a),
        .data_operandB  (b),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: an operation started on edge T0 completes on edge T0+32.
    logic        live = 1'b0;
    int          pend = -1;
    logic [63:0] prod = '0;
    logic        m_rdy = 1'b0, m_busy = 1'b0, m_exc = 1'b0, m_valid = 1'b0;
    logic [31:0] m_res = '0;

    always @(posedge clock) begin
        if (reset) begin
            live = 1'b1; pend = -1; m_rdy = 1'b0; m_busy = 1'b0;
            m_exc = 1'b0; m_res = '0; m_valid = 1'b1;
        end else begin
            m_rdy = 1'b0;
            if (ctrl_MULT) begin
                prod    = longint'($signed(a)) * longint'($signed(b));
                pend    = 0;
                m_busy  = 1'b1;
                m_exc   = 1'b0;
                m_valid = 1'b0;
            end else if (pend >= 0) begin
                pend++;
                if (pend == 32) begin
                    m_rdy   = 1'b1;
                    m_busy  = 1'b0;
                    m_res   = prod[31:0];
                    m_exc   = (prod[63:31] != '0) && (prod[63:31] != '1);
                    m_valid = 1'b1;
                    pend    = -1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (live) begin
            chk("cyc_rdy", 64'(data_resultRDY), 64'(m_rdy));
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_exc", 64'(data_exception), 64'(m_exc));
            if (m_valid) chk("cyc_result", 64'(data_result), 64'(m_res));
        end
        if (data_resultRDY === 1'b1) rdy_cnt++;
    end

    task automatic pulse(input logic [31:0] x, input logic [31:0] y);
        @(negedge clock);
        a = x; b = y; ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
    endtask

    task automatic wait_rdy(input string name, input logic [31:0] er, input logic ee);
        int cyc = 1;
        while (data_resultRDY !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        chk({name, "_latency"}, 64'(cyc), 64'd33);
        chk({name, "_result"}, 64'(data_result), 64'(er));
        chk({name, "_exc"}, 64'(data_exception), 64'(ee));
        @(negedge clock);
        chk({name, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
        chk({name, "_busy_low"}, 64'(busy), 64'd0);
        chk({name, "_hold"}, 64'(data_result), 64'(er));
    endtask

    task automatic run(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic ee);
        pulse(x, y);
        wait_rdy(name, er, ee);
    endtask

    initial begin
        int r0;
        reset = 1'b1; ctrl_MULT = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        chk("rst_result", 64'(data_result), 64'd0);
        chk("rst_rdy", 64'(data_resultRDY), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_exc", 64'(data_exception), 64'd0);
        reset = 1'b0;

        run("3x4", 32'd3, 32'd4, 32'h0000000C, 1'b0);
        run("m7x6", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0);
        run("6xm7", 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0);
        run("2p16sq", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        run("minx1", 32'h80000000, 32'd1, 32'h80000000, 1'b0);
        run("minxm1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run("minxmin", 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
        run("maxxmax", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1);

        // Abort: restart with new operands partway through.
        r0 = rdy_cnt;
        pulse(32'd5, 32'd5);
        repeat (8) @(negedge clock);
        pulse(32'd9, 32'hFFFFFFFD);
        wait_rdy("abort", 32'hFFFFFFE5, 1'b0);
        chk("abort_one_rdy", 64'(rdy_cnt - r0), 64'd1);

        // Reset in the middle of an operation.
        r0 = rdy_cnt;
        pulse(32'd100, 32'd100);
        repeat (13) @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_result", 64'(data_result), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rdy", 64'(data_resultRDY), 64'd0);
        chk("midrst_exc", 64'(data_exception), 64'd0);
        repeat (40) @(negedge clock);
        chk("midrst_no_rdy", 64'(rdy_cnt - r0), 64'd0);

        // Reset dominates a simultaneous start.
        @(negedge clock);
        reset = 1'b1; ctrl_MULT = 1'b1; a = 32'd7; b = 32'd7;
        @(negedge clock);
        reset = 1'b0; ctrl_MULT = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        chk("rst_start_idle", 64'(busy), 64'd0);

        run("100x100", 32'd100, 32'd100, 32'h00002710, 1'b0);

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
